// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Groups every non-clock signal of the instruction fetch stage.
//   pc            fetch address to the instruction memory
//   inst          instruction word returned by the memory for pc
//   stall         hold pc and the IF/ID register
//   branch_taken  redirect to if_pc_next + branch_offset
//   branch_offset signed offset, in instructions
//   jump          redirect to jump_target
//   jump_target   absolute jump address
//   halt          stop fetching
//   if_inst       IF/ID instruction register
//   if_pc_next    IF/ID register holding fetch pc + PC_STEP
//   if_valid      IF/ID contents are a real instruction
//   halted        fetch FSM sits in HALT
// The fetch stage connects through the master modport; the memory and
// decode side connect through the slave modport.
// ---------------------------------------------------------------------------
interface fetch_stage_if;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [31:0] jump_target;
  logic        halt;
  logic [31:0] if_inst;
  logic [31:0] if_pc_next;
  logic        if_valid;
  logic        halted;

  modport master (
    output pc, if_inst, if_pc_next, if_valid, halted,
    input  inst, stall, branch_taken, branch_offset, jump, jump_target, halt
  );

  modport slave (
    input  pc, if_inst, if_pc_next, if_valid, halted,
    output inst, stall, branch_taken, branch_offset, jump, jump_target, halt
  );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage with a BOOT/RUN/HALT controller and the IF/ID
// pipeline register.
//   clk    single clock, rising-edge state updates
//   reset  asynchronous, active-high reset
//   bus    fetch_stage_if.master: memory address/data, decode-side control
//          (stall, branch, jump, halt) and the IF/ID register outputs
// Parameters:
//   RESET_PC  pc value loaded on reset
//   PC_STEP   sequential increment; memory is word-indexed
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 1
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [31:0] r_pc;
  logic [31:0] r_ifInst;
  logic [31:0] r_ifPcNext;
  logic        r_ifValid;

  logic [31:0] w_pcNext;
  logic [31:0] w_ifInstNext;
  logic [31:0] w_ifPcNextNext;
  logic        w_ifValidNext;
  logic [31:0] w_pcPlusStep;
  logic [31:0] w_offsetExt;
  logic [31:0] w_branchTarget;

  // Branch targets are relative to the pc after the branch instruction,
  // which is exactly what the IF/ID register holds. Arithmetic wraps mod 2^32.
  assign w_pcPlusStep   = r_pc + STEP;
  assign w_offsetExt    = {{16{bus.branch_offset[15]}}, bus.branch_offset};
  assign w_branchTarget = r_ifPcNext + (w_offsetExt * STEP);

  // State and IF/ID register; reset aborts whatever was in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_ifInst   <= 32'h0;
      r_ifPcNext <= 32'h0;
      r_ifValid  <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_pc       <= w_pcNext;
      r_ifInst   <= w_ifInstNext;
      r_ifPcNext <= w_ifPcNextNext;
      r_ifValid  <= w_ifValidNext;
    end
  end

  // Next-state and datapath selection. Everything holds by default, so a
  // stall and the BOOT/HALT states need no explicit assignments. In RUN the
  // priority is halt > jump > branch > stall > sequential; redirects flush
  // the IF/ID register by clearing if_valid only.
  always_comb begin
    w_stateNext    = r_state;
    w_pcNext       = r_pc;
    w_ifInstNext   = r_ifInst;
    w_ifPcNextNext = r_ifPcNext;
    w_ifValidNext  = r_ifValid;
    case (r_state)
      BOOT: begin
        w_stateNext = RUN;
      end
      RUN: begin
        if (bus.halt) begin
          w_stateNext   = HALT;
          w_ifValidNext = 1'b0;
        end else if (bus.jump) begin
          w_pcNext      = bus.jump_target;
          w_ifValidNext = 1'b0;
        end else if (bus.branch_taken) begin
          w_pcNext      = w_branchTarget;
          w_ifValidNext = 1'b0;
        end else if (!bus.stall) begin
          w_pcNext       = w_pcPlusStep;
          w_ifInstNext   = bus.inst;
          w_ifPcNextNext = w_pcPlusStep;
          w_ifValidNext  = 1'b1;
        end
      end
      HALT: begin
        w_stateNext = HALT;
      end
      default: begin
        w_stateNext = BOOT;
      end
    endcase
  end

  assign bus.pc         = r_pc;
  assign bus.if_inst    = r_ifInst;
  assign bus.if_pc_next = r_ifPcNext;
  assign bus.if_valid   = r_ifValid;
  assign bus.halted     = (r_state == HALT);

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Parameters
REQ-001 SHALL provide RESET_PC, default 32'h0000_0000: pc value loaded on reset.
REQ-002 SHALL provide PC_STEP, default 1: sequential pc increment; the instruction memory is word-indexed, so one step is one instruction.

Interface
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pc  output  32  fetch address, driven straight from the pc register to the instruction memory.
REQ-006 inst  input  32  instruction returned combinationally by the instruction memory for the current pc.
REQ-007 stall  input  1  hold pc and the IF/ID register (hazard from decode).
REQ-008 branch_taken  input  1  redirect to the branch target, resolved in decode.
REQ-009 branch_offset  input  16  signed offset, in instructions, relative to if_pc_next.
REQ-010 jump  input  1  redirect to jump_target.
REQ-011 jump_target  input  32  absolute jump address.
REQ-012 halt  input  1  stop fetching.
REQ-013 if_inst  output  32  IF/ID instruction register.
REQ-014 if_pc_next  output  32  IF/ID register holding (fetch pc + PC_STEP).
REQ-015 if_valid  output  1  IF/ID contents are a real instruction.
REQ-016 halted  output  1  FSM is in HALT.

Function
REQ-017 SHALL implement a three-state FSM: BOOT, RUN, HALT.
REQ-018 BOOT SHALL last exactly one cycle after reset deasserts, then move to RUN. During BOOT: pc holds, if_valid=0, inputs are ignored.
REQ-019 In RUN, each cycle SHALL apply exactly one action, chosen by priority: halt > jump > branch_taken > stall > sequential.
REQ-020 Sequential: pc <= pc+PC_STEP; if_inst <= inst; if_pc_next <= pc+PC_STEP; if_valid <= 1.
REQ-021 Stall: pc, if_inst, if_pc_next and if_valid SHALL all hold their values.
REQ-022 Branch: pc <= if_pc_next + sign_extend(branch_offset)*PC_STEP; if_valid <= 0 (flush); if_inst and if_pc_next hold.
REQ-023 Jump: pc <= jump_target; if_valid <= 0 (flush).
REQ-024 Redirects SHALL override stall. jump and branch_taken asserted together SHALL resolve as jump.
REQ-025 Halt: the FSM SHALL go to HALT; pc holds; if_valid <= 0. In HALT, halted=1 and the state is left only by reset.
REQ-026 Latency: an instruction presented at pc in cycle n SHALL appear on if_inst with if_valid=1 in cycle n+1, provided there is no stall, redirect or halt.
REQ-027 All pc arithmetic SHALL be 32-bit modulo 2^32. 32'hFFFF_FFFF + 1 SHALL wrap to 0 with no flag.
REQ-028 A negative branch offset SHALL wrap the same way.
REQ-029 Inputs SHALL NOT be treated as X-safe; X-propagation from the memory is not the block's concern.

Reset
REQ-030 When reset is asserted, regardless of clk, the block SHALL immediately force: pc=RESET_PC, if_inst=0, if_pc_next=0, if_valid=0, halted=0, state=BOOT.
REQ-031 Reset asserted mid-stall, mid-redirect or in HALT SHALL abort the operation with no partial update.

Verification
REQ-032 Sequential fetch: reset release, no controls, 5 cycles -> pc goes 0,0(BOOT),1,2,3,4; if_inst follows memory word pc-1 one cycle later; if_valid=1 from the first RUN edge.
REQ-033 Stall: stall=1 for 2 cycles while pc=3 -> pc stays 3; if_inst and if_pc_next stay stable; when stall drops, sequential fetch resumes at pc=4.
REQ-034 Branch: if_pc_next=5, branch_offset=16'hFFFE, branch_taken=1 -> next pc=3 and if_valid=0 for one cycle. With branch_offset=16'h0004 -> next pc=9.
REQ-035 Priority: jump=1, jump_target=32'h40, branch_taken=1 and stall=1 together -> pc=32'h40, if_valid=0.
REQ-036 Wrap and halt: jump to 32'hFFFF_FFFF, then one sequential cycle -> pc=0. Then halt=1 -> halted=1, pc frozen for 10 cycles; async reset mid-cycle -> pc=0 and halted=0 before the next edge.
